// File: rtl/mem_bist_if.sv
// Data-port bus between the BIST master and cpu_interface's dmem_* port.
// master: the BIST engine; slave: cpu_interface (or a memory model).
interface mem_bist_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) ();
    logic                  dmem_read;
    logic                  dmem_write;
    logic [ADDR_W-1:0]     dmem_addr;
    logic [DATA_W-1:0]     dmem_wdata;
    logic [DATA_W/8-1:0]   dmem_ben;
    logic [DATA_W-1:0]     dmem_rdata;
    logic                  mem_stall;

    modport master (
        output dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_ben,
        input  dmem_rdata, mem_stall
    );

    modport slave (
        input  dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_ben,
        output dmem_rdata, mem_stall
    );
endinterface

// File: rtl/mem_bist_engine.sv
// Memory self-test master: writes a pattern over a strided address range, reads it
// back and counts mismatches. Optional first-failure log when MEM_BIST_ERRLOG_EN
// is defined (adds fail_vld_o/fail_addr_o/fail_exp_o/fail_act_o).
module mem_bist_engine #(
    parameter int          ADDR_W    = 30,
    parameter int          DATA_W    = 32,
    parameter int unsigned BASE_ADDR = 0,
    parameter int          WORDS     = 256,
    parameter int unsigned STRIDE    = 32,
    parameter int          ERR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [1:0]        mode_i,
    mem_bist_if.master        bus,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ERR_W-1:0]  err_cnt_o,
    output logic [7:0]        led_o
`ifdef MEM_BIST_ERRLOG_EN
    ,
    output logic              fail_vld_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic [DATA_W-1:0] fail_exp_o,
    output logic [DATA_W-1:0] fail_act_o
`endif
);
    localparam int                IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(STRIDE);
    localparam logic [DATA_W-1:0] WALK_INIT = DATA_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   walk_q, walk_d;     // walk-one bit, rotated once per access
    logic [1:0]          mode_q, mode_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                pass_q, pass_d;
    logic [7:0]          led_q, led_d;
    logic [DATA_W-1:0]   exp_w;
    logic                last_w;
    logic                mismatch_w;
`ifdef MEM_BIST_ERRLOG_EN
    logic                fvld_q, fvld_d;
    logic [ADDR_W-1:0]   faddr_q, faddr_d;
    logic [DATA_W-1:0]   fexp_q, fexp_d;
    logic [DATA_W-1:0]   fact_q, fact_d;
`endif

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        mode,
                                                  input logic [IDX_W-1:0]  idx,
                                                  input logic [ADDR_W-1:0] addr,
                                                  input logic [DATA_W-1:0] walk);
        logic [DATA_W-1:0] addr_ext;
        addr_ext = DATA_W'(addr);
        case (mode)
            2'd0:    pattern = walk;
            2'd1:    pattern = addr_ext;
            2'd2:    pattern = idx[0] ? {DATA_W/8{8'hAA}} : {DATA_W/8{8'h55}};
            default: pattern = ~addr_ext;
        endcase
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        sat_inc = (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
    endfunction

    assign exp_w      = pattern(mode_q, idx_q, addr_q, walk_q);
    assign last_w     = (idx_q == IDX_LAST);
    assign mismatch_w = (bus.dmem_rdata != exp_w);

    // Bus requests come straight from the state so reset drops them at once.
    assign bus.dmem_write = (state_q == S_WRITE);
    assign bus.dmem_read  = (state_q == S_READ);
    assign bus.dmem_addr  = (state_q == S_WRITE || state_q == S_READ) ? addr_q : '0;
    assign bus.dmem_wdata = (state_q == S_WRITE) ? exp_w : '0;
    assign bus.dmem_ben   = (state_q == S_WRITE) ? '1 : '0;

    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign pass_o    = pass_q;
    assign err_cnt_o = err_q;
    assign led_o     = led_q;
`ifdef MEM_BIST_ERRLOG_EN
    assign fail_vld_o  = fvld_q;
    assign fail_addr_o = faddr_q;
    assign fail_exp_o  = fexp_q;
    assign fail_act_o  = fact_q;
`endif

    // Next-state: sequencing, address/pattern stepping, compare and result tracking.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        walk_d  = walk_q;
        mode_d  = mode_q;
        err_d   = err_q;
        pass_d  = pass_q;
        led_d   = led_q;
`ifdef MEM_BIST_ERRLOG_EN
        fvld_d  = fvld_q;
        faddr_d = faddr_q;
        fexp_d  = fexp_q;
        fact_d  = fact_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_WRITE;
                    idx_d   = '0;
                    addr_d  = ADDR_BASE;
                    walk_d  = WALK_INIT;
                    mode_d  = mode_i;
                    err_d   = '0;
                    pass_d  = 1'b0;
`ifdef MEM_BIST_ERRLOG_EN
                    fvld_d  = 1'b0;
                    faddr_d = '0;
                    fexp_d  = '0;
                    fact_d  = '0;
`endif
                end
            end
            S_WRITE: begin
                // Abort is only honoured once the pending write has been accepted.
                if (!bus.mem_stall) begin
                    if (abort_i) begin
                        state_d = S_DONE;
                    end else if (last_w) begin
                        state_d = S_READ;
                        idx_d   = '0;
                        addr_d  = ADDR_BASE;
                        walk_d  = WALK_INIT;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        addr_d = addr_q + ADDR_STEP;
                        walk_d = {walk_q[DATA_W-2:0], walk_q[DATA_W-1]};
                    end
                end
            end
            S_READ: begin
                if (!bus.mem_stall) begin
                    led_d = bus.dmem_rdata[7:0];
                    if (mismatch_w) begin
                        err_d = sat_inc(err_q);
`ifdef MEM_BIST_ERRLOG_EN
                        if (!fvld_q) begin
                            fvld_d  = 1'b1;
                            faddr_d = addr_q;
                            fexp_d  = exp_w;
                            fact_d  = bus.dmem_rdata;
                        end
`endif
                    end
                    if (abort_i) begin
                        state_d = S_DONE;
                    end else if (last_w) begin
                        state_d = S_DONE;
                        pass_d  = (err_d == '0);
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        addr_d = addr_q + ADDR_STEP;
                        walk_d = {walk_q[DATA_W-2:0], walk_q[DATA_W-1]};
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            walk_q  <= '0;
            mode_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            led_q   <= '0;
`ifdef MEM_BIST_ERRLOG_EN
            fvld_q  <= 1'b0;
            faddr_q <= '0;
            fexp_q  <= '0;
            fact_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            walk_q  <= walk_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            led_q   <= led_d;
`ifdef MEM_BIST_ERRLOG_EN
            fvld_q  <= fvld_d;
            faddr_q <= faddr_d;
            fexp_q  <= fexp_d;
            fact_q  <= fact_d;
`endif
        end
    end
endmodule

// File: tb/tb_mem_bist_engine.sv
// Directed bench for mem_bist_engine: two instances (4-word run from address 0,
// and a 2-word run that wraps past the top of the address space), each with a
// small memory model that can stall and inject a single-bit fault.
module tb_mem_bist_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, abort_a = 1'b0;
    logic [1:0]  mode_a = 2'd0;
    logic        busy_a, done_a, pass_a;
    logic [15:0] err_a;
    logic [7:0]  led_a;
    logic        start_b = 1'b0, abort_b = 1'b0;
    logic [1:0]  mode_b = 2'd0;
    logic        busy_b, done_b, pass_b;
    logic [15:0] err_b;
    logic [7:0]  led_b;
`ifdef MEM_BIST_ERRLOG_EN
    logic        fvld_a, fvld_b;
    logic [29:0] faddr_a, faddr_b;
    logic [31:0] fexp_a, fact_a, fexp_b, fact_b;
`endif

    mem_bist_if #(.ADDR_W(30), .DATA_W(32)) bus_a ();
    mem_bist_if #(.ADDR_W(30), .DATA_W(32)) bus_b ();

    mem_bist_engine #(.ADDR_W(30), .DATA_W(32), .BASE_ADDR(0), .WORDS(4),
                      .STRIDE(32), .ERR_W(16)) dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .abort_i(abort_a), .mode_i(mode_a),
        .bus(bus_a), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
        .err_cnt_o(err_a), .led_o(led_a)
`ifdef MEM_BIST_ERRLOG_EN
        , .fail_vld_o(fvld_a), .fail_addr_o(faddr_a), .fail_exp_o(fexp_a), .fail_act_o(fact_a)
`endif
    );

    mem_bist_engine #(.ADDR_W(30), .DATA_W(32), .BASE_ADDR(32'h3FFF_FFE0), .WORDS(2),
                      .STRIDE(32), .ERR_W(16)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .abort_i(abort_b), .mode_i(mode_b),
        .bus(bus_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
        .err_cnt_o(err_b), .led_o(led_b)
`ifdef MEM_BIST_ERRLOG_EN
        , .fail_vld_o(fvld_b), .fail_addr_o(faddr_b), .fail_exp_o(fexp_b), .fail_act_o(fact_b)
`endif
    );

    // Memory model A: 4 words at addr[6:5], programmable stall, optional bit-0 fault at 64.
    int          stall_n = 0;
    logic        flip_a = 1'b0;
    int          wait_a = 0;
    logic [31:0] mem_a [4];
    logic [29:0] wr_addr_a [64];
    logic [31:0] wr_data_a [64];
    int          wr_cnt_a = 0, rd_cnt_a = 0, unstable_a = 0, both_a = 0;
    logic        stl_a = 1'b0, pr_a = 1'b0, pw_a = 1'b0;
    logic [29:0] pa_a = '0;
    logic [31:0] pd_a = '0;

    always_comb begin
        bus_a.mem_stall  = (bus_a.dmem_read || bus_a.dmem_write) && (wait_a < stall_n);
        bus_a.dmem_rdata = mem_a[bus_a.dmem_addr[6:5]]
                           ^ {31'd0, flip_a && (bus_a.dmem_addr == 30'd64)};
    end

    always @(posedge clk) begin
        if (stl_a && (pr_a != bus_a.dmem_read || pw_a != bus_a.dmem_write ||
                      pa_a != bus_a.dmem_addr || pd_a != bus_a.dmem_wdata))
            unstable_a <= unstable_a + 1;
        if (bus_a.dmem_read && bus_a.dmem_write) both_a <= both_a + 1;
        stl_a <= (bus_a.dmem_read || bus_a.dmem_write) && bus_a.mem_stall;
        pr_a  <= bus_a.dmem_read;
        pw_a  <= bus_a.dmem_write;
        pa_a  <= bus_a.dmem_addr;
        pd_a  <= bus_a.dmem_wdata;
        if ((bus_a.dmem_read || bus_a.dmem_write) && bus_a.mem_stall) wait_a <= wait_a + 1;
        else wait_a <= 0;
        if (bus_a.dmem_write && !bus_a.mem_stall) begin
            mem_a[bus_a.dmem_addr[6:5]] <= bus_a.dmem_wdata;
            wr_addr_a[wr_cnt_a[5:0]]    <= bus_a.dmem_addr;
            wr_data_a[wr_cnt_a[5:0]]    <= bus_a.dmem_wdata;
            wr_cnt_a <= wr_cnt_a + 1;
        end
        if (bus_a.dmem_read && !bus_a.mem_stall) rd_cnt_a <= rd_cnt_a + 1;
    end

    // Memory model B: 2 words at addr[5], never stalls.
    logic [31:0] mem_b [2];
    logic [29:0] wr_addr_b [8];
    logic [31:0] wr_data_b [8];
    int          wr_cnt_b = 0, rd_cnt_b = 0;

    always_comb begin
        bus_b.mem_stall  = 1'b0;
        bus_b.dmem_rdata = mem_b[bus_b.dmem_addr[5]];
    end

    always @(posedge clk) begin
        if (bus_b.dmem_write) begin
            mem_b[bus_b.dmem_addr[5]] <= bus_b.dmem_wdata;
            wr_addr_b[wr_cnt_b[2:0]]  <= bus_b.dmem_addr;
            wr_data_b[wr_cnt_b[2:0]]  <= bus_b.dmem_wdata;
            wr_cnt_b <= wr_cnt_b + 1;
        end
        if (bus_b.dmem_read) rd_cnt_b <= rd_cnt_b + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_a(input logic [1:0] m);
        @(negedge clk);
        mode_a  = m;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done(input bit use_b, input int budget, output int cyc);
        cyc = 0;
        while (((use_b ? done_b : done_a) !== 1'b1) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk(use_b ? "done_seen_b" : "done_seen_a", 64'(use_b ? done_b : done_a), 64'd1);
    endtask

    initial begin : seq
        int cyc;
        int w0;
        int r0;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_pass", 64'(pass_a), 64'd0);
        chk("rst_err", 64'(err_a), 64'd0);
        chk("rst_led", 64'(led_a), 64'd0);
        chk("rst_req", 64'({bus_a.dmem_read, bus_a.dmem_write}), 64'd0);
        chk("rst_addr", 64'(bus_a.dmem_addr), 64'd0);
        chk("rst_ben", 64'(bus_a.dmem_ben), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        abort_a = 1'b1;                       // abort while idle must do nothing
        @(negedge clk);
        chk("idle_abort_busy", 64'(busy_a), 64'd0);
        abort_a = 1'b0;

        // 1: addr-as-data, no stall
        w0 = wr_cnt_a; r0 = rd_cnt_a;
        pulse_a(2'd1);
        mode_a = 2'd3;                        // mode is latched at start
        chk("t1_write", 64'(bus_a.dmem_write), 64'd1);
        chk("t1_addr0", 64'(bus_a.dmem_addr), 64'd0);
        chk("t1_ben", 64'(bus_a.dmem_ben), 64'hF);
        chk("t1_busy", 64'(busy_a), 64'd1);
        wait_done(1'b0, 40, cyc);
        chk("t1_latency", 64'(cyc), 64'd8);
        chk("t1_pass", 64'(pass_a), 64'd1);
        chk("t1_err", 64'(err_a), 64'd0);
        chk("t1_wr_cnt", 64'(wr_cnt_a - w0), 64'd4);
        chk("t1_rd_cnt", 64'(rd_cnt_a - r0), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk("t1_wr_addr", 64'(wr_addr_a[6'(w0 + k)]), 64'(32 * k));
            chk("t1_wr_data", 64'(wr_data_a[6'(w0 + k)]), 64'(32 * k));
        end
        chk("t1_led", 64'(led_a), 64'h60);
`ifdef MEM_BIST_ERRLOG_EN
        chk("t1_fvld", 64'(fvld_a), 64'd0);
`endif
        @(negedge clk);
        chk("t1_done_1cyc", 64'(done_a), 64'd0);
        chk("t1_idle", 64'(busy_a), 64'd0);

        // 2: walk-one with 3 stall cycles per access
        stall_n = 3;
        w0 = wr_cnt_a; r0 = rd_cnt_a; n = unstable_a;
        pulse_a(2'd0);
        wait_done(1'b0, 100, cyc);
        chk("t2_completions", 64'((wr_cnt_a - w0) + (rd_cnt_a - r0)), 64'd8);
        chk("t2_stable", 64'(unstable_a - n), 64'd0);
        chk("t2_wdata1", 64'(wr_data_a[6'(w0 + 1)]), 64'h2);
        chk("t2_wdata3", 64'(wr_data_a[6'(w0 + 3)]), 64'h8);
        chk("t2_led", 64'(led_a), 64'h08);
        chk("t2_pass", 64'(pass_a), 64'd1);
        stall_n = 0;

        // 3: checkerboard with a bit-0 fault at address 64
        flip_a = 1'b1;
        pulse_a(2'd2);
        chk("t3_pass_cleared", 64'(pass_a), 64'd0);
        wait_done(1'b0, 40, cyc);
        chk("t3_err", 64'(err_a), 64'd1);
        chk("t3_pass", 64'(pass_a), 64'd0);
        chk("t3_led", 64'(led_a), 64'hAA);
`ifdef MEM_BIST_ERRLOG_EN
        chk("t3_fvld", 64'(fvld_a), 64'd1);
        chk("t3_faddr", 64'(faddr_a), 64'd64);
        chk("t3_fexp", 64'(fexp_a), 64'h5555_5555);
        chk("t3_fact", 64'(fact_a), 64'h5555_5554);
`endif
        flip_a = 1'b0;

        // 4: abort during the stalled second write
        stall_n = 3;
        w0 = wr_cnt_a; r0 = rd_cnt_a;
        pulse_a(2'd1);
        chk("t4_err_cleared", 64'(err_a), 64'd0);
        n = 0;
        while (!(bus_a.dmem_write && bus_a.dmem_addr == 30'd32 && bus_a.mem_stall) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t4_reach_w2", 64'(n < 50), 64'd1);
        abort_a = 1'b1;
        wait_done(1'b0, 40, cyc);
        chk("t4_wr_cnt", 64'(wr_cnt_a - w0), 64'd2);
        chk("t4_rd_cnt", 64'(rd_cnt_a - r0), 64'd0);
        chk("t4_pass", 64'(pass_a), 64'd0);
        @(negedge clk);
        chk("t4_busy", 64'(busy_a), 64'd0);
        @(negedge clk);
        chk("t4_idle_read", 64'(bus_a.dmem_read), 64'd0);
        abort_a = 1'b0;
        stall_n = 0;
        chk("t4_never_both", 64'(both_a), 64'd0);

        // 5: wrapping address range, start held during the run
        @(negedge clk);
        mode_b  = 2'd1;
        start_b = 1'b1;
        repeat (3) @(negedge clk);
        start_b = 1'b0;
        wait_done(1'b1, 20, cyc);
        chk("t5_latency", 64'(cyc), 64'd2);
        chk("t5_wr_cnt", 64'(wr_cnt_b), 64'd2);
        chk("t5_rd_cnt", 64'(rd_cnt_b), 64'd2);
        chk("t5_addr0", 64'(wr_addr_b[0]), 64'h3FFF_FFE0);
        chk("t5_addr1", 64'(wr_addr_b[1]), 64'h0);
        chk("t5_data0", 64'(wr_data_b[0]), 64'h3FFF_FFE0);
        chk("t5_pass", 64'(pass_b), 64'd1);
        @(negedge clk);
        chk("t5_no_restart", 64'(busy_b), 64'd0);
`ifdef MEM_BIST_ERRLOG_EN
        chk("t5_fvld", 64'(fvld_b), 64'd0);
`endif

        // 6: reset in the middle of the read phase
        pulse_a(2'd1);
        n = 0;
        while (!bus_a.dmem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("t6_mid_read", 64'(bus_a.dmem_read), 64'd1);
        chk("t6_led_pre", 64'(led_a), 64'h20);
        rst = 1'b1;
        #1;
        chk("t6_rst_req", 64'({bus_a.dmem_read, bus_a.dmem_write}), 64'd0);
        chk("t6_rst_busy", 64'(busy_a), 64'd0);
        chk("t6_rst_led", 64'(led_a), 64'd0);
        chk("t6_rst_addr", 64'(bus_a.dmem_addr), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        pulse_a(2'd3);
        wait_done(1'b0, 40, cyc);
        chk("t6_pass", 64'(pass_a), 64'd1);
        chk("t6_err", 64'(err_a), 64'd0);
        chk("t6_led", 64'(led_a), 64'h9F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end
endmodule
